// File: rtl/cipher_sequencer.sv
// cipher_sequencer: key load, warm-up and keystream word sequencer for the stream cipher core
module cipher_sequencer #(
  parameter int KEY_BYTES = 10,
  parameter int WARMUP_CYCLES = 160,
  parameter int WORD_BITS = 8,
  parameter int MAX_WORDS = 1024
) (
  input  logic clk,
  input  logic nrst,
  input  logic key_load_req,
  input  logic key_byte_valid,
  output logic key_byte_ready,
  input  logic word_req,
  input  logic output_acknowledge,
  output logic core_load_en,
  output logic core_init_en,
  output logic core_step_en,
  output logic ks_capture,
  output logic output_is_ready,
  output logic keyed,
  output logic busy,
  output logic err_unkeyed
);
  localparam int BW = $clog2(KEY_BYTES + 1);
  localparam int WW = $clog2(WARMUP_CYCLES + 1);
  localparam int SW = $clog2(WORD_BITS + 1);
  localparam logic [BW-1:0] LAST_BYTE = BW'(KEY_BYTES - 1);
  localparam logic [WW-1:0] LAST_WARM = WW'(WARMUP_CYCLES - 1);
  localparam logic [SW-1:0] LAST_BIT = SW'(WORD_BITS - 1);
  typedef enum logic [2:0] {SQ_UNKEYED, SQ_LOAD, SQ_WARMUP, SQ_IDLE, SQ_GEN, SQ_READY} state_t;
  state_t state, next;
  logic [BW-1:0] byte_cnt;
  logic [WW-1:0] warm_cnt;
  logic [SW-1:0] bit_cnt;
  logic last_word;
  assign core_load_en = key_byte_valid & key_byte_ready;
  always_comb begin
    case (state)
      SQ_UNKEYED: next = key_load_req ? SQ_LOAD : SQ_UNKEYED;
      SQ_LOAD:    next = (core_load_en && byte_cnt == LAST_BYTE) ? SQ_WARMUP : SQ_LOAD;
      SQ_WARMUP:  next = (warm_cnt == LAST_WARM) ? SQ_IDLE : SQ_WARMUP;
      SQ_IDLE:    next = key_load_req ? SQ_LOAD : word_req ? SQ_GEN : SQ_IDLE;
      SQ_GEN:     next = (bit_cnt == LAST_BIT) ? SQ_READY : SQ_GEN;
      SQ_READY:   next = !output_acknowledge ? SQ_READY : last_word ? SQ_UNKEYED : SQ_IDLE;
      default:    next = SQ_UNKEYED;
    endcase
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= SQ_UNKEYED;
      byte_cnt <= '0;
      warm_cnt <= '0;
      bit_cnt <= '0;
      key_byte_ready <= 1'b0;
      core_init_en <= 1'b0;
      core_step_en <= 1'b0;
      ks_capture <= 1'b0;
      output_is_ready <= 1'b0;
      keyed <= 1'b0;
      busy <= 1'b0;
      err_unkeyed <= 1'b0;
    end else begin
      state <= next;
      byte_cnt <= (state == SQ_LOAD) ? byte_cnt + BW'(core_load_en) : '0;
      warm_cnt <= (state == SQ_WARMUP) ? warm_cnt + 1'b1 : '0;
      bit_cnt <= (state == SQ_GEN) ? bit_cnt + 1'b1 : '0;
      key_byte_ready <= next == SQ_LOAD;
      core_init_en <= next == SQ_WARMUP;
      core_step_en <= next == SQ_GEN;
      ks_capture <= next == SQ_GEN;
      output_is_ready <= next == SQ_READY;
      keyed <= next inside {SQ_IDLE, SQ_GEN, SQ_READY};
      busy <= next inside {SQ_LOAD, SQ_WARMUP, SQ_GEN};
      err_unkeyed <= (state == SQ_UNKEYED) ? ~key_load_req & (word_req | err_unkeyed) : err_unkeyed;
    end
  end
`ifdef CIPHER_SEQ_WORD_LIMIT_EN
  localparam int NW = $clog2(MAX_WORDS + 1);
  logic [NW-1:0] word_cnt;
  assign last_word = word_cnt == NW'(MAX_WORDS - 1);
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) word_cnt <= '0;
    else if (state == SQ_WARMUP && next == SQ_IDLE) word_cnt <= '0;
    else if (state == SQ_READY && output_acknowledge) word_cnt <= word_cnt + 1'b1;
  end
`else
  assign last_word = 1'b0;
`endif
  enables_exclusive: assert property (@(posedge clk) disable iff (!nrst)
    $onehot0({core_load_en, core_init_en, core_step_en}));
endmodule

// File: tb/tb_cipher_sequencer.sv
// tb_cipher_sequencer: directed bench for cipher_sequencer with a word-length scoreboard
module tb_cipher_sequencer;
  localparam int WORD_BITS = 8;
`ifdef CIPHER_SEQ_WORD_LIMIT_EN
  localparam int LIMIT = 3;
`else
  localparam int LIMIT = 0;
`endif
  logic clk = 1'b0, nrst = 1'b0;
  logic key_load_req = 1'b0, key_byte_valid = 1'b0, word_req = 1'b0, ack = 1'b0;
  logic key_byte_ready, core_load_en, core_init_en, core_step_en, ks_capture;
  logic output_is_ready, keyed, busy, err_unkeyed;
  logic [8:0] outs;
  int checks = 0, failures = 0;
  int cnt_load = 0, cnt_init = 0, cnt_step = 0, step_run = 0, nwords = 0;
  logic prev_ready = 1'b0;
  int sb[$];
  always #5 clk = ~clk;
  cipher_sequencer #(.MAX_WORDS(LIMIT == 0 ? 1024 : LIMIT)) dut (
    .clk(clk), .nrst(nrst),
    .key_load_req(key_load_req), .key_byte_valid(key_byte_valid),
    .key_byte_ready(key_byte_ready), .word_req(word_req),
    .output_acknowledge(ack), .core_load_en(core_load_en),
    .core_init_en(core_init_en), .core_step_en(core_step_en),
    .ks_capture(ks_capture), .output_is_ready(output_is_ready),
    .keyed(keyed), .busy(busy), .err_unkeyed(err_unkeyed)
  );
  assign outs = {key_byte_ready, core_load_en, core_init_en, core_step_en, ks_capture,
                 output_is_ready, keyed, busy, err_unkeyed};
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  always @(negedge clk) begin
    if (!nrst) begin
      step_run = 0;
      prev_ready = 1'b0;
    end else begin
      cnt_load += int'(core_load_en);
      cnt_init += int'(core_init_en);
      cnt_step += int'(core_step_en);
      step_run += int'(core_step_en);
      chk("enable_exclusive", 32'($countones({core_load_en, core_init_en, core_step_en})) <= 1, 1);
      chk("capture_tracks_step", ks_capture, core_step_en);
      if (output_is_ready && !prev_ready) begin
        if (sb.size() == 0) chk("sb_unexpected_word", 1, 0);
        else chk("sb_word_bits", step_run, sb.pop_front());
        step_run = 0;
      end
      prev_ready = output_is_ready;
    end
  end
  task automatic start_load();
    key_load_req = 1'b1;
    tick();
    key_load_req = 1'b0;
    chk("load_ready", {key_byte_ready, busy, keyed}, 3'b110);
    chk("err_cleared", err_unkeyed, 0);
  endtask
  task automatic feed_key(input bit gapped);
    int n = 0, c = 0;
    cnt_load = 0;
    cnt_init = 0;
    while (n < 10 && c < 100) begin
      key_byte_valid = !gapped || (c % 3 == 0);
      n += int'(key_byte_valid);
      c++;
      tick();
    end
    key_byte_valid = 1'b0;
    chk("load_count", cnt_load, 10);
    chk("warm_start", {key_byte_ready, core_init_en, busy, keyed}, 4'b0110);
    tick(159);
    chk("warm_last", {core_init_en, keyed}, 2'b10);
    tick();
    chk("keyed_set", {core_init_en, keyed, busy}, 3'b010);
    chk("init_count", cnt_init, 160);
    nwords = 0;
  endtask
  task automatic gen_word(input bit hold, input bit kl);
    int s0;
    s0 = cnt_step;
    word_req = 1'b1;
    sb.push_back(WORD_BITS);
    tick();
    chk("gen_start", {core_step_en, busy, output_is_ready}, 3'b110);
    word_req = hold;
    key_load_req = kl;
    tick(7);
    chk("gen_last", {core_step_en, output_is_ready}, 2'b10);
    word_req = 1'b0;
    key_load_req = 1'b0;
    tick();
    chk("ready_set", {core_step_en, output_is_ready, busy, keyed}, 4'b0101);
    chk("step_count", cnt_step - s0, WORD_BITS);
    tick(2);
    chk("ready_holds", output_is_ready, 1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    nwords++;
    chk("ready_clear", {output_is_ready, core_step_en, busy}, 0);
    chk("keyed_after_word", keyed, (LIMIT == 0 || nwords < LIMIT));
    tick(3);
    chk("no_extra_step", cnt_step - s0, WORD_BITS);
  endtask
  initial begin
    tick(2);
    chk("reset_outs", outs, 0);
    nrst = 1'b1;
    tick();
    chk("post_reset_outs", outs, 0);
    word_req = 1'b1;
    tick();
    word_req = 1'b0;
    chk("unkeyed_err", {err_unkeyed, core_load_en, core_init_en, core_step_en, busy}, 5'b10000);
    tick();
    chk("err_sticky", err_unkeyed, 1);
    start_load();
    feed_key(1'b0);
    gen_word(1'b0, 1'b0);
    gen_word(1'b1, 1'b1);
    key_load_req = 1'b1;
    word_req = 1'b1;
    tick();
    key_load_req = 1'b0;
    word_req = 1'b0;
    chk("rekey_priority", {key_byte_ready, core_step_en, keyed}, 3'b100);
    feed_key(1'b1);
    word_req = 1'b1;
    tick();
    word_req = 1'b0;
    tick(3);
    chk("mid_gen_active", core_step_en, 1);
    nrst = 1'b0;
    #1;
    chk("mid_gen_reset_outs", outs, 0);
    tick();
    nrst = 1'b1;
    tick();
    chk("after_gen_reset", outs, 0);
    start_load();
    key_byte_valid = 1'b1;
    tick(10);
    key_byte_valid = 1'b0;
    tick(50);
    chk("mid_warm_active", core_init_en, 1);
    nrst = 1'b0;
    #1;
    chk("mid_warm_reset_outs", outs, 0);
    tick();
    nrst = 1'b1;
    tick();
    chk("after_warm_reset", outs, 0);
    word_req = 1'b1;
    tick();
    word_req = 1'b0;
    chk("unkeyed_after_reset", {err_unkeyed, keyed, core_step_en}, 3'b100);
    start_load();
    feed_key(1'b0);
    gen_word(1'b0, 1'b0);
    gen_word(1'b0, 1'b0);
    gen_word(1'b0, 1'b0);
`ifdef CIPHER_SEQ_WORD_LIMIT_EN
    word_req = 1'b1;
    tick();
    word_req = 1'b0;
    chk("limit_err", {err_unkeyed, keyed, core_step_en, busy}, 4'b1000);
`endif
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
